servo_aim_ctrl: RTL and testbench
=================================

SERVO_AIM_CTRL -- requirements
Module: servo_aim_ctrl

Interface
REQ-001 The block SHALL use these parameters (name, default, meaning):
- PWM_PERIOD, 500000, servo frame length in clk cycles (20 ms at 25 MHz).
- PULSE_MIN, 25000, minimum pulse width (1.0 ms).
- PULSE_MAX, 50000, maximum pulse width (2.0 ms).
- PULSE_HOME, 37500, home/centre pulse width (1.5 ms).
- CX, 320, screen centre x.
- CY, 240, screen centre y.
- DEADBAND, 16, pixel error magnitude treated as zero.
- KP, 4, pulse counts per pixel of error.
- MAX_STEP, 1000, per-frame step limit.
- HOME_STEP, 500, per-frame homing step.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-high reset.
- v_sync, in, 1, frame sync shared with the tracker.
- aim_x, in, 10, tracked x.
- aim_y, in, 10, tracked y.
- aim_detected, in, 1, target present this frame.
- target_off, in, 1, target lost for 3 s or longer.
- pan_pwm, out, 1, pan servo pulse.
- tilt_pwm, out, 1, tilt servo pulse.
- pan_pos, out, 16, commanded pan pulse width.
- tilt_pos, out, 16, commanded tilt pulse width.
- state, out, 2, 0=HOLD, 1=TRACK, 2=HOME.
- on_target, out, 1, detected and both errors within the deadband.

Function
REQ-003 A v_sync rising edge SHALL be detected as v_sync=1 with the registered previous value 0; one update SHALL occur exactly 2 clk cycles after the edge cycle, so tracker outputs have settled.
REQ-004 Only the update cycle SHALL change state, pan_pos, tilt_pos or on_target; all other cycles hold them.
REQ-005 State selection at update, in priority order: aim_detected=1 -> TRACK; else target_off=1 -> HOME; else HOLD.
REQ-006 TRACK axis arithmetic:
- err = aim - centre, signed 11-bit.
- If |err| <= DEADBAND, the axis SHALL be unchanged.
- Otherwise step = err*KP, clamped to ±MAX_STEP.
- New position = old position + step, saturated to [PULSE_MIN, PULSE_MAX].
- pan uses x/CX; tilt uses y/CY.
REQ-007 Intermediate arithmetic SHALL be signed and at least 18 bits wide, so that no step or sum wraps.
REQ-008 HOLD SHALL keep both positions unchanged.
REQ-009 HOME axis behaviour:
- If |pos - PULSE_HOME| <= HOME_STEP, the position SHALL equal PULSE_HOME.
- Otherwise the position SHALL move HOME_STEP toward PULSE_HOME.
REQ-010 on_target SHALL be 1 only when the update is in TRACK and both |err| values are <= DEADBAND; otherwise it is 0.
REQ-011 Each axis SHALL have PWM output as follows:
- A shared 19-bit counter runs 0..PWM_PERIOD-1 and wraps to 0.
- Each axis latches its position into a pulse register on the cycle the counter is 0.
- The PWM output SHALL be registered and high while counter < latched pulse.
REQ-012 A position change mid-period SHALL NOT alter the current pulse; it takes effect from the next counter=0.
REQ-013 If an update and a counter=0 cycle coincide, the latch SHALL take the pre-update position.
REQ-014 The PWM outputs SHALL be glitch-free, with exactly one high pulse per period.

Reset
REQ-015 Reset assertion SHALL immediately set the following, regardless of any operation in progress:
- pan_pos = tilt_pos = PULSE_HOME.
- Both latched pulses = PULSE_HOME.
- Counter = 0; pan_pwm = tilt_pwm = 0.
- state = HOLD; on_target = 0.
- Edge and delay registers = 0.
REQ-016 After reset release, the first PWM pulse SHALL begin on the first clk edge, with width PULSE_HOME.
REQ-017 A v_sync already high at release SHALL NOT be treated as an edge.

Verification
REQ-018 Deadband: aim=(330,250), detected, one edge -> pan_pos=tilt_pos=37500, on_target=1, state=1.
REQ-019 Proportional step: aim=(400,200), detected -> pan_pos=37820, tilt_pos=37340, on_target=0.
REQ-020 Clamping and saturation: aim_x=639, detected, 20 edges -> steps of +1000, then pan_pos held at 50000.
REQ-021 Homing: pan_pos=40000, aim_detected=0, target_off=1, edges -> 39500, 39000, 38500, 38000, 37500, then stays; state=2.
REQ-022 PWM timing:
- Measure pan_pwm high for 37500 cycles per 500000-cycle period.
- Update pan_pos mid-period -> the current pulse width is unchanged and the next pulse uses the new width.
REQ-023 Reset mid-operation: assert reset during a pan_pwm high pulse in TRACK -> pan_pwm=0 within the same cycle and all REQ-015 values hold.

Source files
------------

// File: rtl/servo_aim_ctrl.sv
// Pan/tilt servo aiming controller: frame-synchronous proportional tracking with homing,
// plus two PWM generators that only pick up a new pulse width at the start of each period.
module servo_aim_ctrl #(
  parameter int PWM_PERIOD = 500000,
  parameter int PULSE_MIN  = 25000,
  parameter int PULSE_MAX  = 50000,
  parameter int PULSE_HOME = 37500,
  parameter int CX         = 320,
  parameter int CY         = 240,
  parameter int DEADBAND   = 16,
  parameter int KP         = 4,
  parameter int MAX_STEP   = 1000,
  parameter int HOME_STEP  = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        v_sync,
  input  logic [9:0]  aim_x,
  input  logic [9:0]  aim_y,
  input  logic        aim_detected,
  input  logic        target_off,
  output logic        pan_pwm,
  output logic        tilt_pwm,
  output logic [15:0] pan_pos,
  output logic [15:0] tilt_pos,
  output logic [1:0]  state,
  output logic        on_target
);

  localparam logic [1:0] S_HOLD  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_HOME  = 2'd2;

  localparam logic signed [19:0] CX_S    = 20'(CX);
  localparam logic signed [19:0] CY_S    = 20'(CY);
  localparam logic signed [19:0] DB_S    = 20'(DEADBAND);
  localparam logic signed [19:0] KP_S    = 20'(KP);
  localparam logic signed [19:0] MSTEP_S = 20'(MAX_STEP);
  localparam logic signed [19:0] HSTEP_S = 20'(HOME_STEP);
  localparam logic signed [19:0] PMIN_S  = 20'(PULSE_MIN);
  localparam logic signed [19:0] PMAX_S  = 20'(PULSE_MAX);
  localparam logic signed [19:0] HOME_S  = 20'(PULSE_HOME);
  localparam logic [15:0]        HOME_U  = 16'(PULSE_HOME);
  localparam logic [18:0]        PER_M1  = 19'(PWM_PERIOD - 1);

  function automatic logic in_band(input logic [9:0] aim, input logic signed [19:0] centre);
    logic signed [19:0] err;
    err = $signed({10'b0, aim}) - centre;
    in_band = (err <= DB_S) && (err >= -DB_S);
  endfunction

  function automatic logic [15:0] track_axis(input logic [15:0] pos, input logic [9:0] aim,
                                             input logic signed [19:0] centre);
    logic signed [19:0] err, step, sum;
    err  = $signed({10'b0, aim}) - centre;
    step = err * KP_S;
    if (step > MSTEP_S) step = MSTEP_S;
    else if (step < -MSTEP_S) step = -MSTEP_S;
    sum = $signed({4'b0, pos}) + step;
    if (sum > PMAX_S) sum = PMAX_S;
    else if (sum < PMIN_S) sum = PMIN_S;
    track_axis = in_band(aim, centre) ? pos : sum[15:0];
  endfunction

  function automatic logic [15:0] home_axis(input logic [15:0] pos);
    logic signed [19:0] diff, nxt;
    diff = $signed({4'b0, pos}) - HOME_S;
    if ((diff <= HSTEP_S) && (diff >= -HSTEP_S)) nxt = HOME_S;
    else if (diff > 0) nxt = $signed({4'b0, pos}) - HSTEP_S;
    else nxt = $signed({4'b0, pos}) + HSTEP_S;
    home_axis = nxt[15:0];
  endfunction

  logic        vs_prev_q, arm_q;
  logic [1:0]  dly_q;
  logic [1:0]  state_q, state_d;
  logic [15:0] pan_q, pan_d, tilt_q, tilt_d;
  logic        ot_q, ot_d;
  logic [18:0] cnt_q, cnt_d;
  logic [15:0] pan_lat_q, pan_lat_d, tilt_lat_q, tilt_lat_d;
  logic        pan_pwm_q, pan_pwm_d, tilt_pwm_q, tilt_pwm_d;
  logic        edge_w, upd;

  // arm_q blocks a v_sync that is already high when reset is released
  assign edge_w = v_sync & ~vs_prev_q & arm_q;
  assign upd    = dly_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_HOLD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (upd) begin
      if (aim_detected)    state_d = S_TRACK;
      else if (target_off) state_d = S_HOME;
      else                 state_d = S_HOLD;
    end
  end

  always_comb begin
    pan_d  = pan_q;
    tilt_d = tilt_q;
    ot_d   = ot_q;
    if (upd) begin
      ot_d = 1'b0;
      case (state_d)
        S_TRACK: begin
          pan_d  = track_axis(pan_q, aim_x, CX_S);
          tilt_d = track_axis(tilt_q, aim_y, CY_S);
          ot_d   = in_band(aim_x, CX_S) & in_band(aim_y, CY_S);
        end
        S_HOME: begin
          pan_d  = home_axis(pan_q);
          tilt_d = home_axis(tilt_q);
        end
        default: ;
      endcase
    end
  end

  // Latch uses the registered position, so a coincident update lands next period
  always_comb begin
    cnt_d      = (cnt_q == PER_M1) ? 19'd0 : cnt_q + 19'd1;
    pan_lat_d  = (cnt_q == 19'd0) ? pan_q  : pan_lat_q;
    tilt_lat_d = (cnt_q == 19'd0) ? tilt_q : tilt_lat_q;
    pan_pwm_d  = cnt_q < {3'b0, pan_lat_d};
    tilt_pwm_d = cnt_q < {3'b0, tilt_lat_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev_q  <= 1'b0;
      arm_q      <= 1'b0;
      dly_q      <= 2'b00;
      pan_q      <= HOME_U;
      tilt_q     <= HOME_U;
      ot_q       <= 1'b0;
      cnt_q      <= 19'd0;
      pan_lat_q  <= HOME_U;
      tilt_lat_q <= HOME_U;
      pan_pwm_q  <= 1'b0;
      tilt_pwm_q <= 1'b0;
    end else begin
      vs_prev_q  <= v_sync;
      arm_q      <= 1'b1;
      dly_q      <= {dly_q[0], edge_w};
      pan_q      <= pan_d;
      tilt_q     <= tilt_d;
      ot_q       <= ot_d;
      cnt_q      <= cnt_d;
      pan_lat_q  <= pan_lat_d;
      tilt_lat_q <= tilt_lat_d;
      pan_pwm_q  <= pan_pwm_d;
      tilt_pwm_q <= tilt_pwm_d;
    end
  end

  always_comb begin
    state     = state_q;
    pan_pos   = pan_q;
    tilt_pos  = tilt_q;
    on_target = ot_q;
    pan_pwm   = pan_pwm_q;
    tilt_pwm  = tilt_pwm_q;
  end

endmodule

// File: tb/tb_servo_aim_ctrl.sv
// Bench for servo_aim_ctrl: a default-parameter instance for the aiming arithmetic and
// a short-period instance for PWM timing, both on shared inputs.
module tb_servo_aim_ctrl;
  localparam int CXP = 320, CYP = 240, DB = 16, KPP = 4, MSTEP = 1000, HSTEP = 500;
  localparam int PMIN = 25000, PMAX = 50000, PHOME = 37500;
  localparam int S_PER = 2000, S_MIN = 100, S_MAX = 600, S_HOME = 150;

  logic clk = 1'b0, reset = 1'b1, v_sync = 1'b0;
  logic [9:0] aim_x = 10'd320, aim_y = 10'd240;
  logic aim_detected = 1'b0, target_off = 1'b0;

  logic b_pan_pwm, b_tilt_pwm, b_on_target, s_pan_pwm, s_tilt_pwm, s_on_target;
  logic [15:0] b_pan_pos, b_tilt_pos, s_pan_pos, s_tilt_pos;
  logic [1:0] b_state, s_state;

  int checks = 0, errors = 0;
  int m_pan, m_tilt, m_state, m_ot;
  int run = 0;
  int wq[$];

  typedef struct {int x; int y; int det; int off; int pan; int tilt; int st; int ot;} vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  servo_aim_ctrl u_big (
    .clk(clk), .reset(reset), .v_sync(v_sync), .aim_x(aim_x), .aim_y(aim_y),
    .aim_detected(aim_detected), .target_off(target_off),
    .pan_pwm(b_pan_pwm), .tilt_pwm(b_tilt_pwm), .pan_pos(b_pan_pos), .tilt_pos(b_tilt_pos),
    .state(b_state), .on_target(b_on_target));

  servo_aim_ctrl #(.PWM_PERIOD(S_PER), .PULSE_MIN(S_MIN), .PULSE_MAX(S_MAX), .PULSE_HOME(S_HOME)) u_small (
    .clk(clk), .reset(reset), .v_sync(v_sync), .aim_x(aim_x), .aim_y(aim_y),
    .aim_detected(aim_detected), .target_off(target_off),
    .pan_pwm(s_pan_pwm), .tilt_pwm(s_tilt_pwm), .pan_pos(s_pan_pos), .tilt_pos(s_tilt_pos),
    .state(s_state), .on_target(s_on_target));

  // Pulse-width monitor on the short-period pan output
  always @(negedge clk) begin
    if (reset) run = 0;
    else if (s_pan_pwm) run++;
    else if (run > 0) begin
      wq.push_back(run);
      run = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int m_track(input int pos, input int aim, input int c);
    int err, step;
    err = aim - c;
    if (iabs(err) <= DB) return pos;
    step = err * KPP;
    if (step > MSTEP) step = MSTEP;
    if (step < -MSTEP) step = -MSTEP;
    pos = pos + step;
    if (pos > PMAX) pos = PMAX;
    if (pos < PMIN) pos = PMIN;
    return pos;
  endfunction

  function automatic int m_home(input int pos);
    if (iabs(pos - PHOME) <= HSTEP) return PHOME;
    return (pos > PHOME) ? pos - HSTEP : pos + HSTEP;
  endfunction

  task automatic model_frame(input int x, input int y, input int det, input int off);
    if (det != 0) begin
      m_state = 1;
      m_ot    = (iabs(x - CXP) <= DB && iabs(y - CYP) <= DB) ? 1 : 0;
      m_pan   = m_track(m_pan, x, CXP);
      m_tilt  = m_track(m_tilt, y, CYP);
    end else if (off != 0) begin
      m_state = 2;
      m_ot    = 0;
      m_pan   = m_home(m_pan);
      m_tilt  = m_home(m_tilt);
    end else begin
      m_state = 0;
      m_ot    = 0;
    end
  endtask

  task automatic frame(input int x, input int y, input int det, input int off);
    @(posedge clk);
    #1;
    aim_x = 10'(x);
    aim_y = 10'(y);
    aim_detected = (det != 0);
    target_off = (off != 0);
    v_sync = 1'b1;
    @(posedge clk);
    #1 v_sync = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    model_frame(x, y, det, off);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pan"}, int'(b_pan_pos), m_pan);
    chk({tag, ".tilt"}, int'(b_tilt_pos), m_tilt);
    chk({tag, ".state"}, int'(b_state), m_state);
    chk({tag, ".on_target"}, int'(b_on_target), m_ot);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    v_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_pan = PHOME; m_tilt = PHOME; m_state = 0; m_ot = 0;
  endtask

  task automatic wait_widths(input int n, input string name);
    int t;
    t = 0;
    while (wq.size() < n && t < 3 * S_PER) begin
      @(posedge clk);
      #1 t++;
    end
    if (wq.size() < n) chk({name, ".timeout"}, wq.size(), n);
  endtask

  task automatic wait_pwm_high(input string name);
    int t;
    t = 0;
    while (s_pan_pwm !== 1'b1 && t < 3 * S_PER) begin
      @(posedge clk);
      #1 t++;
    end
    if (s_pan_pwm !== 1'b1) chk({name, ".timeout"}, int'(s_pan_pwm), 1);
  endtask

  initial begin
    int exp;
    int homeseq[6];
    tbl[0] = '{330, 250, 1, 0, 37500, 37500, 1, 1};
    tbl[1] = '{400, 200, 1, 0, 37820, 37340, 1, 0};
    tbl[2] = '{320, 240, 0, 0, 37820, 37340, 0, 0};
    tbl[3] = '{0,   479, 0, 1, 37500, 37500, 2, 0};
    tbl[4] = '{0,   0,   1, 1, 36500, 36540, 1, 0};
    tbl[5] = '{336, 256, 1, 0, 36500, 36540, 1, 1};
    tbl[6] = '{337, 240, 1, 0, 36568, 36540, 1, 0};
    homeseq = '{39500, 39000, 38500, 38000, 37500, 37500};

    // Reset state, with v_sync and a live target already present at release
    aim_x = 10'd400; aim_detected = 1'b1; v_sync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.pan", int'(b_pan_pos), PHOME);
    chk("rst.tilt", int'(b_tilt_pos), PHOME);
    chk("rst.state", int'(b_state), 0);
    chk("rst.on_target", int'(b_on_target), 0);
    chk("rst.pan_pwm", int'(s_pan_pwm), 0);
    chk("rst.tilt_pwm", int'(s_tilt_pwm), 0);
    reset = 1'b0;
    m_pan = PHOME; m_tilt = PHOME; m_state = 0; m_ot = 0;
    @(posedge clk);
    #1 chk("first_pulse_start", int'(s_pan_pwm), 1);
    chk("first_pulse_start_big", int'(b_pan_pwm), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("held_vsync.pan", int'(b_pan_pos), PHOME);
    chk("held_vsync.state", int'(b_state), 0);
    v_sync = 1'b0; aim_detected = 1'b0; aim_x = 10'd320;

    // PWM widths and a mid-pulse position change
    wait_widths(1, "pwm_w0");
    if (wq.size() >= 1) chk("pwm_width0", wq[0], S_HOME);
    wait_pwm_high("pwm_rise");
    frame(400, 240, 1, 0);
    check_all("pwm_frame");
    chk("small.pan", int'(s_pan_pos), 470);
    wait_widths(3, "pwm_w2");
    if (wq.size() >= 3) begin
      chk("pwm_width_during_update", wq[1], S_HOME);
      chk("pwm_width_next", wq[2], 470);
    end

    // Table-driven vectors from reset
    do_reset();
    for (int i = 0; i < 7; i++) begin
      frame(tbl[i].x, tbl[i].y, tbl[i].det, tbl[i].off);
      chk($sformatf("vec%0d.pan", i), int'(b_pan_pos), tbl[i].pan);
      chk($sformatf("vec%0d.tilt", i), int'(b_tilt_pos), tbl[i].tilt);
      chk($sformatf("vec%0d.state", i), int'(b_state), tbl[i].st);
      chk($sformatf("vec%0d.on_target", i), int'(b_on_target), tbl[i].ot);
    end

    // Randomized frames against the reference model
    for (int i = 0; i < 40; i++) begin
      int x, y;
      x = ($urandom_range(0, 2) == 0) ? CXP - 20 + int'($urandom_range(0, 40)) : int'($urandom_range(0, 1023));
      y = ($urandom_range(0, 2) == 0) ? CYP - 20 + int'($urandom_range(0, 40)) : int'($urandom_range(0, 1023));
      frame(x, y, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      check_all($sformatf("rand%0d", i));
    end

    // Step clamp then saturation at PULSE_MAX
    do_reset();
    exp = PHOME;
    for (int i = 0; i < 20; i++) begin
      frame(639, 240, 1, 0);
      exp = (exp + 1000 > PMAX) ? PMAX : exp + 1000;
      chk($sformatf("clamp%0d.pan", i), int'(b_pan_pos), exp);
    end

    // Homing from 40000
    do_reset();
    frame(639, 240, 1, 0);
    frame(639, 240, 1, 0);
    frame(445, 240, 1, 0);
    chk("home_start.pan", int'(b_pan_pos), 40000);
    for (int i = 0; i < 6; i++) begin
      frame(0, 0, 0, 1);
      chk($sformatf("home%0d.pan", i), int'(b_pan_pos), homeseq[i]);
      chk($sformatf("home%0d.state", i), int'(b_state), 2);
    end

    // Reset asserted during a pulse while tracking
    frame(400, 240, 1, 0);
    chk("pre_reset.state", int'(s_state), 1);
    wait_pwm_high("rst_rise");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst.pan_pwm", int'(s_pan_pwm), 0);
    chk("midrst.tilt_pwm", int'(s_tilt_pwm), 0);
    chk("midrst.big_pan_pwm", int'(b_pan_pwm), 0);
    chk("midrst.pan", int'(s_pan_pos), S_HOME);
    chk("midrst.big_pan", int'(b_pan_pos), PHOME);
    chk("midrst.big_tilt", int'(b_tilt_pos), PHOME);
    chk("midrst.state", int'(b_state), 0);
    chk("midrst.on_target", int'(b_on_target), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
